// File: rtl/cp0_reg_pkg.sv
// Shared definitions for the CP0 register file.
//   - EXC_TYPE_* : encoded exception type driven by the MEM exception logic.
//                  Same numbering as Cause.ExcCode, except INT, which is moved to 1
//                  so it cannot be confused with "no exception".
//   - CP0_REG_*  : mtc0/mfc0 register numbers.
//   - Status/Cause bit positions.
//   - exc_code() : turns an EXC_TYPE_* value into its 5-bit ExcCode.
package cp0_reg_pkg;

   localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
   localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
   localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
   localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
   localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
   localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
   localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
   localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
   localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

   localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
   localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_REG_EPC      = 5'd14;
   localparam logic [4:0] CP0_REG_PRID     = 5'd15;

   localparam int STATUS_IE_BIT  = 0;
   localparam int STATUS_EXL_BIT = 1;
   localparam int STATUS_IM_LO   = 8;
   localparam int STATUS_IM_HI   = 15;
   localparam int STATUS_BEV_BIT = 22;

   localparam int CAUSE_EXC_LO   = 2;
   localparam int CAUSE_EXC_HI   = 6;
   localparam int CAUSE_IPSW_LO  = 8;
   localparam int CAUSE_IPSW_HI  = 9;
   localparam int CAUSE_IPHW_LO  = 10;
   localparam int CAUSE_IPHW_HI  = 15;
   localparam int CAUSE_TI_BIT   = 30;
   localparam int CAUSE_BD_BIT   = 31;

   function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
      return (exc_type == EXC_TYPE_INT) ? 5'h00 : exc_type[4:0];
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer.
//   clk, resetn            : clock, async active-low reset
//   count_we, compare_we   : qualified mtc0 writes (already suppressed on commit)
//   wdata                  : mtc0 data
//   count_o, compare_o     : current Count / Compare
//   ti_o                   : timer interrupt flag (Cause.TI)
// Count advances once every COUNT_DIV cycles (1 or 2). A Count write replaces
// that cycle's increment but leaves the tick phase running.
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        ti_o
);

   logic        phase_q, phase_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        ti_q, ti_d;
   logic        tick;
   logic [31:0] count_inc;

   always_comb begin
      count_inc = count_q + 32'd1;
      tick      = (COUNT_DIV == 1) ? 1'b1 : phase_q;
      phase_d   = ~phase_q;

      count_d = count_q;
      if (count_we)
         count_d = wdata;
      else if (tick)
         count_d = count_inc;

      compare_d = compare_we ? wdata : compare_q;

      // A Compare write clears TI even if a match happens on the same edge.
      ti_d = ti_q;
      if (tick && !count_we && (count_inc == compare_q))
         ti_d = 1'b1;
      if (compare_we)
         ti_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         phase_q   <= 1'b0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: commits MEM-stage exceptions / ERET into
// Status, Cause, EPC and BadVAddr, services mtc0/mfc0, and hosts the
// Count/Compare timer.
//   clk, resetn                 : clock, async active-low reset
//   we_i, waddr_i, wdata_i      : mtc0 write port
//   raddr_i, rdata_o            : mfc0 read port (combinational, pre-edge values)
//   ext_int                     : hardware interrupt lines -> Cause.IP[7:2]
//   except_type, is_in_delayslot, pcM, badvaddrM : exception commit inputs
//   status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, timer_int_o
module cp0_reg
   import cp0_reg_pkg::*;
#(
   parameter logic [31:0] PRID_VAL  = 32'h0000_4220,
   parameter int          COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_i,
   output logic [31:0] rdata_o,
   input  logic [5:0]  ext_int,
   input  logic [31:0] except_type,
   input  logic        is_in_delayslot,
   input  logic [31:0] pcM,
   input  logic [31:0] badvaddrM,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] badvaddr_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o
);

   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_hw_q, ip_hw_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badvaddr_q, badvaddr_d;

   logic exc_valid, eret, mtc0;
   logic ti;

   // A faulting or returning instruction must not retire, so its mtc0 is dropped.
   assign exc_valid = (except_type != EXC_TYPE_NOEXC) && (except_type != EXC_TYPE_ERET);
   assign eret      = (except_type == EXC_TYPE_ERET);
   assign mtc0      = we_i && !exc_valid && !eret;

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .count_we   (mtc0 && (waddr_i == CP0_REG_COUNT)),
      .compare_we (mtc0 && (waddr_i == CP0_REG_COMPARE)),
      .wdata      (wdata_i),
      .count_o    (count_o),
      .compare_o  (compare_o),
      .ti_o       (ti)
   );

   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_sw_d    = ip_sw_q;
      exccode_d  = exccode_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      // IP7 also carries the timer interrupt.
      ip_hw_d    = {ext_int[5] | ti, ext_int[4:0]};

      if (mtc0) begin
         case (waddr_i)
            CP0_REG_STATUS: begin
               im_d  = wdata_i[STATUS_IM_HI:STATUS_IM_LO];
               exl_d = wdata_i[STATUS_EXL_BIT];
               ie_d  = wdata_i[STATUS_IE_BIT];
            end
            CP0_REG_CAUSE: ip_sw_d = wdata_i[CAUSE_IPSW_HI:CAUSE_IPSW_LO];
            CP0_REG_EPC:   epc_d   = wdata_i;
            default: ;
         endcase
      end

      if (exc_valid) begin
         // Nested exception keeps the original return point.
         if (!exl_q) begin
            epc_d = is_in_delayslot ? (pcM - 32'd4) : pcM;
            bd_d  = is_in_delayslot;
         end
         exl_d     = 1'b1;
         exccode_d = exc_code(except_type);
         if ((except_type == EXC_TYPE_ADEL) || (except_type == EXC_TYPE_ADES))
            badvaddr_d = badvaddrM;
      end else if (eret) begin
         exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_hw_q    <= '0;
         ip_sw_q    <= '0;
         exccode_q  <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
      end
   end

   always_comb begin
      status_o = '0;
      status_o[STATUS_BEV_BIT]             = 1'b1;
      status_o[STATUS_IM_HI:STATUS_IM_LO]  = im_q;
      status_o[STATUS_EXL_BIT]             = exl_q;
      status_o[STATUS_IE_BIT]              = ie_q;

      cause_o = '0;
      cause_o[CAUSE_BD_BIT]                = bd_q;
      cause_o[CAUSE_TI_BIT]                = ti;
      cause_o[CAUSE_IPHW_HI:CAUSE_IPHW_LO] = ip_hw_q;
      cause_o[CAUSE_IPSW_HI:CAUSE_IPSW_LO] = ip_sw_q;
      cause_o[CAUSE_EXC_HI:CAUSE_EXC_LO]   = exccode_q;
   end

   assign epc_o       = epc_q;
   assign badvaddr_o  = badvaddr_q;
   assign timer_int_o = ti;

   always_comb begin
      case (raddr_i)
         CP0_REG_BADVADDR: rdata_o = badvaddr_q;
         CP0_REG_COUNT:    rdata_o = count_o;
         CP0_REG_COMPARE:  rdata_o = compare_o;
         CP0_REG_STATUS:   rdata_o = status_o;
         CP0_REG_CAUSE:    rdata_o = cause_o;
         CP0_REG_EPC:      rdata_o = epc_q;
         CP0_REG_PRID:     rdata_o = PRID_VAL;
         default:          rdata_o = '0;
      endcase
   end

endmodule
